// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse packet assembler: FSM states,
// byte0 bit positions and axis width.
package ps2_pkg;

    typedef enum logic [1:0] {
        WAIT_B0,
        WAIT_B1,
        WAIT_B2,
        PUBLISH
    } ps2_state_t;

    localparam int unsigned B0_SYNC  = 3;
    localparam int unsigned B0_XSIGN = 4;
    localparam int unsigned B0_YSIGN = 5;
    localparam int unsigned B0_XOVF  = 6;
    localparam int unsigned B0_YOVF  = 7;

    localparam int unsigned AXIS_W = 9;

    localparam logic [AXIS_W-1:0] AXIS_NEG_SAT = 9'h100;
    localparam logic [AXIS_W-1:0] AXIS_POS_SAT = 9'h0FF;

endpackage

// File: rtl/ps2_gap_timer.sv
// Inter-byte gap counter: counts while run is high, saturates at
// TIMEOUT_CYCLES and raises expired there; clear has priority.
module ps2_gap_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (run && (count_q != LIMIT)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = (count_q == LIMIT);

endmodule

// File: rtl/ps2_packet_assembler.sv
// Builds 3-byte PS/2 mouse packets with resync and gap timeout.
// Optional overflow saturation: define PS2_PKT_SATURATE_EN.
module ps2_packet_assembler
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              byte_err,
    output logic [AXIS_W-1:0] x_axis,
    output logic [AXIS_W-1:0] y_axis,
    output logic [2:0]        buttons,
    output logic              package_done,
    output logic              pkt_err
);

    ps2_state_t state_q, state_d;

    logic take_b0, take_b1, take_b2;
    logic err_d;
    logic timer_run, timer_clear, expired;

    logic [2:0] b0_btn_q;
    logic       b0_xs_q, b0_ys_q;
`ifdef PS2_PKT_SATURATE_EN
    logic       b0_xo_q, b0_yo_q;
`endif
    logic [7:0] b1_q;

    logic [AXIS_W-1:0] x_d, y_d;

    ps2_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk    (clk),
        .rst    (rst),
        .run    (timer_run),
        .clear  (timer_clear),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= WAIT_B0;
        end else begin
            state_q <= state_d;
        end
    end

    // PUBLISH treats an incoming byte exactly like WAIT_B0 does.
    always_comb begin
        state_d = state_q;
        take_b0 = 1'b0;
        take_b1 = 1'b0;
        take_b2 = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            WAIT_B0, PUBLISH: begin
                state_d = WAIT_B0;
                if (byte_valid) begin
                    if (byte_err || !byte_data[B0_SYNC]) begin
                        err_d = 1'b1;
                    end else begin
                        take_b0 = 1'b1;
                        state_d = WAIT_B1;
                    end
                end
            end
            WAIT_B1: begin
                if (byte_valid) begin
                    if (byte_err) begin
                        err_d   = 1'b1;
                        state_d = WAIT_B0;
                    end else begin
                        take_b1 = 1'b1;
                        state_d = WAIT_B2;
                    end
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = WAIT_B0;
                end
            end
            WAIT_B2: begin
                if (byte_valid) begin
                    if (byte_err) begin
                        err_d   = 1'b1;
                        state_d = WAIT_B0;
                    end else begin
                        take_b2 = 1'b1;
                        state_d = PUBLISH;
                    end
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = WAIT_B0;
                end
            end
            default: state_d = WAIT_B0;
        endcase
    end

    assign timer_run   = (state_q == WAIT_B1) || (state_q == WAIT_B2);
    assign timer_clear = take_b0 || take_b1 || take_b2 ||
                         (state_d == WAIT_B0) || (state_d == PUBLISH);

    always_comb begin
        x_d = {b0_xs_q, b1_q};
        y_d = {b0_ys_q, byte_data};
`ifdef PS2_PKT_SATURATE_EN
        if (b0_xo_q) x_d = b0_xs_q ? AXIS_NEG_SAT : AXIS_POS_SAT;
        if (b0_yo_q) y_d = b0_ys_q ? AXIS_NEG_SAT : AXIS_POS_SAT;
`endif
    end

    // Data loads on the third byte; the done strobe follows one cycle later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            b0_btn_q     <= '0;
            b0_xs_q      <= 1'b0;
            b0_ys_q      <= 1'b0;
`ifdef PS2_PKT_SATURATE_EN
            b0_xo_q      <= 1'b0;
            b0_yo_q      <= 1'b0;
`endif
            b1_q         <= '0;
            x_axis       <= '0;
            y_axis       <= '0;
            buttons      <= '0;
            package_done <= 1'b0;
            pkt_err      <= 1'b0;
        end else begin
            package_done <= (state_q == PUBLISH);
            pkt_err      <= err_d;
            if (take_b0) begin
                b0_btn_q <= byte_data[2:0];
                b0_xs_q  <= byte_data[B0_XSIGN];
                b0_ys_q  <= byte_data[B0_YSIGN];
`ifdef PS2_PKT_SATURATE_EN
                b0_xo_q  <= byte_data[B0_XOVF];
                b0_yo_q  <= byte_data[B0_YOVF];
`endif
            end
            if (take_b1) begin
                b1_q <= byte_data;
            end
            if (take_b2) begin
                x_axis  <= x_d;
                y_axis  <= y_d;
                buttons <= b0_btn_q;
            end
        end
    end

endmodule

// File: tb/tb_ps2_packet_assembler.sv
// Self-checking bench for ps2_packet_assembler: directed vector table,
// hand-written timeout/reset sequences, and randomized traffic vs. a model.
module tb_ps2_packet_assembler;

    localparam int unsigned TMO = 20;

`ifdef PS2_PKT_SATURATE_EN
    localparam logic [8:0] XO = 9'h0FF;
    localparam logic [8:0] YO = 9'h0FF;
`else
    localparam logic [8:0] XO = 9'h010;
    localparam logic [8:0] YO = 9'h005;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = '0;
    logic       byte_err = 1'b0;
    logic [8:0] x_axis, y_axis;
    logic [2:0] buttons;
    logic       package_done, pkt_err;

    int checks = 0;
    int errors = 0;

    ps2_packet_assembler #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_err    (byte_err),
        .x_axis      (x_axis),
        .y_axis      (y_axis),
        .buttons     (buttons),
        .package_done(package_done),
        .pkt_err     (pkt_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (packet-level view) ----------------
    logic [7:0] m_part[$];
    int         m_idle;
    bit         m_pub;
    logic [8:0] m_x, m_y;
    logic [2:0] m_btn;
    logic       m_done, m_err;

    task automatic model_reset();
        m_part.delete();
        m_idle = 0;
        m_pub  = 0;
        m_x = '0; m_y = '0; m_btn = '0;
        m_done = 0; m_err = 0;
    endtask

    task automatic model_publish();
        int xv, yv;
        logic [7:0] b0;
        b0 = m_part[0];
        xv = b0[4] ? int'(m_part[1]) - 256 : int'(m_part[1]);
        yv = b0[5] ? int'(m_part[2]) - 256 : int'(m_part[2]);
`ifdef PS2_PKT_SATURATE_EN
        if (b0[6]) xv = b0[4] ? -256 : 255;
        if (b0[7]) yv = b0[5] ? -256 : 255;
`endif
        m_x   = 9'(xv);
        m_y   = 9'(yv);
        m_btn = b0[2:0];
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic e);
        m_done = m_pub;
        m_pub  = 0;
        m_err  = 0;
        if (v) begin
            m_idle = 0;
            if (e) begin
                m_part.delete();
                m_err = 1;
            end else if (m_part.size() == 0) begin
                if (d[3]) m_part.push_back(d);
                else      m_err = 1;
            end else begin
                m_part.push_back(d);
                if (m_part.size() == 3) begin
                    model_publish();
                    m_part.delete();
                    m_pub = 1;
                end
            end
        end else if (m_part.size() != 0) begin
            if (m_idle == int'(TMO)) begin
                m_part.delete();
                m_err  = 1;
                m_idle = 0;
            end else begin
                m_idle++;
            end
        end
    endtask

    // ---------------- helpers ----------------
    function automatic logic [22:0] pack(input logic done, input logic err,
                                         input logic [2:0] btn, input logic [8:0] x,
                                         input logic [8:0] y);
        return {done, err, btn, x, y};
    endfunction

    task automatic check(input string name, input logic [22:0] exp);
        logic [22:0] got;
        got = pack(package_done, pkt_err, buttons, x_axis, y_axis);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: done/err/btn/x/y got %0b/%0b/%0h/%03h/%03h required %0b/%0b/%0h/%03h/%03h",
                     name, got[22], got[21], got[20:18], got[17:9], got[8:0],
                     exp[22], exp[21], exp[20:18], exp[17:9], exp[8:0]);
        end
    endtask

    task automatic tick(input logic r, input logic v, input logic [7:0] d, input logic e);
        rst = r; byte_valid = v; byte_data = d; byte_err = e;
        @(posedge clk);
        if (!r) model_reset();
        else    model_step(v, d, e);
        #1;
    endtask

    task automatic step(input string name, input logic v, input logic [7:0] d,
                        input logic e, input logic [22:0] exp);
        tick(1'b1, v, d, e);
        check(name, exp);
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       e;
        logic [22:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [7:0] d, input logic e,
                       input logic done, input logic err, input logic [2:0] btn,
                       input logic [8:0] x, input logic [8:0] y);
        vec_t t;
        t.v = v; t.d = d; t.e = e;
        t.exp = pack(done, err, btn, x, y);
        vecs.push_back(t);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) tick(1'b0, 1'b0, 8'h00, 1'b0);
        check("reset", pack(0, 0, 3'd0, 9'h000, 9'h000));

        // normal packet
        add(1, 8'h18, 0, 0, 0, 3'd0, 9'h000, 9'h000);
        add(1, 8'h05, 0, 0, 0, 3'd0, 9'h000, 9'h000);
        add(1, 8'hFB, 0, 0, 0, 3'd0, 9'h105, 9'h0FB);
        add(0, 8'h00, 0, 1, 0, 3'd0, 9'h105, 9'h0FB);
        add(0, 8'h00, 0, 0, 0, 3'd0, 9'h105, 9'h0FB);
        // resync on missing sync bit
        add(1, 8'h05, 0, 0, 1, 3'd0, 9'h105, 9'h0FB);
        add(1, 8'h08, 0, 0, 0, 3'd0, 9'h105, 9'h0FB);
        add(1, 8'h10, 0, 0, 0, 3'd0, 9'h105, 9'h0FB);
        add(1, 8'h20, 0, 0, 0, 3'd0, 9'h010, 9'h020);
        add(0, 8'h00, 0, 1, 0, 3'd0, 9'h010, 9'h020);
        add(0, 8'h00, 0, 0, 0, 3'd0, 9'h010, 9'h020);
        // error mid-packet
        add(1, 8'h08, 0, 0, 0, 3'd0, 9'h010, 9'h020);
        add(1, 8'h44, 1, 0, 1, 3'd0, 9'h010, 9'h020);
        add(1, 8'h09, 0, 0, 0, 3'd0, 9'h010, 9'h020);
        add(1, 8'h02, 0, 0, 0, 3'd0, 9'h010, 9'h020);
        add(1, 8'h03, 0, 0, 0, 3'd1, 9'h002, 9'h003);
        add(0, 8'h00, 0, 1, 0, 3'd1, 9'h002, 9'h003);
        // back-to-back, byte0 taken during the publish cycle
        add(1, 8'h0A, 0, 0, 0, 3'd1, 9'h002, 9'h003);
        add(1, 8'h01, 0, 0, 0, 3'd1, 9'h002, 9'h003);
        add(1, 8'h02, 0, 0, 0, 3'd2, 9'h001, 9'h002);
        add(1, 8'h1C, 0, 1, 0, 3'd2, 9'h001, 9'h002);
        add(1, 8'hFF, 0, 0, 0, 3'd2, 9'h001, 9'h002);
        add(1, 8'h00, 0, 0, 0, 3'd4, 9'h1FF, 9'h000);
        add(1, 8'h05, 0, 1, 1, 3'd4, 9'h1FF, 9'h000);
        add(0, 8'h00, 0, 0, 0, 3'd4, 9'h1FF, 9'h000);
        // overflow handling
        add(1, 8'h58, 0, 0, 0, 3'd4, 9'h1FF, 9'h000);
        add(1, 8'h00, 0, 0, 0, 3'd4, 9'h1FF, 9'h000);
        add(1, 8'h00, 0, 0, 0, 3'd0, 9'h100, 9'h000);
        add(0, 8'h00, 0, 1, 0, 3'd0, 9'h100, 9'h000);
        add(1, 8'h48, 0, 0, 0, 3'd0, 9'h100, 9'h000);
        add(1, 8'h10, 0, 0, 0, 3'd0, 9'h100, 9'h000);
        add(1, 8'h00, 0, 0, 0, 3'd0, XO,     9'h000);
        add(0, 8'h00, 0, 1, 0, 3'd0, XO,     9'h000);
        add(1, 8'h88, 0, 0, 0, 3'd0, XO,     9'h000);
        add(1, 8'h00, 0, 0, 0, 3'd0, XO,     9'h000);
        add(1, 8'h05, 0, 0, 0, 3'd0, 9'h000, YO);
        add(0, 8'h00, 0, 1, 0, 3'd0, 9'h000, YO);
        // byte_err on an otherwise valid byte0
        add(1, 8'h08, 1, 0, 1, 3'd0, 9'h000, YO);
        add(0, 8'h00, 0, 0, 0, 3'd0, 9'h000, YO);

        rst = 1'b1;
        for (int i = 0; i < vecs.size(); i++)
            step($sformatf("vec%0d", i), vecs[i].v, vecs[i].d, vecs[i].e, vecs[i].exp);

        // timeout while waiting for byte1
        step("tmo1_b0", 1, 8'h09, 0, pack(0, 0, 3'd0, 9'h000, YO));
        for (int k = 0; k <= int'(TMO); k++)
            step($sformatf("tmo1_idle%0d", k), 0, 8'h00, 0,
                 pack(0, (k == int'(TMO)), 3'd0, 9'h000, YO));
        step("tmo1_p0", 1, 8'h08, 0, pack(0, 0, 3'd0, 9'h000, YO));
        step("tmo1_p1", 1, 8'h01, 0, pack(0, 0, 3'd0, 9'h000, YO));
        step("tmo1_p2", 1, 8'h01, 0, pack(0, 0, 3'd0, 9'h001, 9'h001));
        step("tmo1_done", 0, 8'h00, 0, pack(1, 0, 3'd0, 9'h001, 9'h001));

        // byte arriving exactly at the limit is accepted
        step("edge_b0", 1, 8'h08, 0, pack(0, 0, 3'd0, 9'h001, 9'h001));
        for (int k = 0; k < int'(TMO); k++)
            step("edge_gap1", 0, 8'h00, 0, pack(0, 0, 3'd0, 9'h001, 9'h001));
        step("edge_b1", 1, 8'h02, 0, pack(0, 0, 3'd0, 9'h001, 9'h001));
        for (int k = 0; k < int'(TMO); k++)
            step("edge_gap2", 0, 8'h00, 0, pack(0, 0, 3'd0, 9'h001, 9'h001));
        step("edge_b2", 1, 8'h03, 0, pack(0, 0, 3'd0, 9'h002, 9'h003));
        step("edge_done", 0, 8'h00, 0, pack(1, 0, 3'd0, 9'h002, 9'h003));

        // timeout while waiting for byte2
        step("tmo2_b0", 1, 8'h0F, 0, pack(0, 0, 3'd0, 9'h002, 9'h003));
        step("tmo2_b1", 1, 8'h77, 0, pack(0, 0, 3'd0, 9'h002, 9'h003));
        for (int k = 0; k <= int'(TMO); k++)
            step("tmo2_idle", 0, 8'h00, 0,
                 pack(0, (k == int'(TMO)), 3'd0, 9'h002, 9'h003));

        // reset mid-packet
        step("rst_b0", 1, 8'h0A, 0, pack(0, 0, 3'd0, 9'h002, 9'h003));
        step("rst_b1", 1, 8'h11, 0, pack(0, 0, 3'd0, 9'h002, 9'h003));
        tick(1'b0, 1'b0, 8'h00, 1'b0);
        check("rst_mid", pack(0, 0, 3'd0, 9'h000, 9'h000));
        step("rst_rel", 0, 8'h00, 0, pack(0, 0, 3'd0, 9'h000, 9'h000));
        step("rst_p0", 1, 8'h0B, 0, pack(0, 0, 3'd0, 9'h000, 9'h000));
        step("rst_p1", 1, 8'h01, 0, pack(0, 0, 3'd0, 9'h000, 9'h000));
        step("rst_p2", 1, 8'h02, 0, pack(0, 0, 3'd3, 9'h001, 9'h002));
        step("rst_done", 0, 8'h00, 0, pack(1, 0, 3'd3, 9'h001, 9'h002));

        // randomized traffic against the packet-level model
        for (int n = 0; n < 4000; n++) begin
            int unsigned r;
            logic [7:0]  d;
            r = $urandom_range(0, 99);
            if (r == 0) begin
                tick(1'b0, 1'b0, 8'h00, 1'b0);
                check("rand_rst", pack(m_done, m_err, m_btn, m_x, m_y));
            end else if (r < 3) begin
                repeat ($urandom_range(TMO - 2, TMO + 3)) begin
                    tick(1'b1, 1'b0, 8'h00, 1'b0);
                    check("rand_gap", pack(m_done, m_err, m_btn, m_x, m_y));
                end
            end else if (r < 40) begin
                d = 8'($urandom);
                if ($urandom_range(0, 9) < 8) d[3] = 1'b1;
                tick(1'b1, 1'b1, d, ($urandom_range(0, 19) == 0));
                check("rand_byte", pack(m_done, m_err, m_btn, m_x, m_y));
            end else begin
                tick(1'b1, 1'b0, 8'h00, 1'b0);
                check("rand_idle", pack(m_done, m_err, m_btn, m_x, m_y));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_packet_assembler.md
# ps2_packet_assembler

Assembles the 3-byte PS/2 mouse movement packet from the byte stream delivered by the PS/2 receiver. Produces signed 9-bit X/Y deltas, button state and a one-cycle `package_done` strobe. Sits directly upstream of the Z-axis accumulator, which consumes `x_axis`, `y_axis` and `package_done`. Also provides packet resynchronisation, so one lost or corrupted byte never shifts the byte framing permanently.

## Interface
- `TIMEOUT_CYCLES`, default 100000: maximum idle gap between bytes of one packet, in `clk` cycles (2 ms at 50 MHz).
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `byte_valid`  in  1  one-cycle strobe; `byte_data` is valid this cycle.
- `byte_data`  in  8  received byte, LSB = first bit on the wire.
- `byte_err`  in  1  qualifies `byte_valid`; parity, start or stop error on this byte.
- `x_axis`  out  9  two's-complement X delta, {byte0[4], byte1}.
- `y_axis`  out  9  two's-complement Y delta, {byte0[5], byte2}.
- `buttons`  out  3  {middle, right, left} = byte0[2:0].
- `package_done`  out  1  one-cycle high strobe; a packet was published.
- `pkt_err`  out  1  one-cycle strobe; a packet was discarded (error, sync or timeout).

## Operation
- FSM states: `WAIT_B0`, `WAIT_B1`, `WAIT_B2`, `PUBLISH`. Reset state is `WAIT_B0`.
- **`WAIT_B0`:**
  - On `byte_valid` with no `byte_err` and `byte_data[3]==1` (sync bit): latch the byte as byte0 and go to `WAIT_B1`.
  - If `byte_data[3]==0`, drop the byte, pulse `pkt_err` and stay in `WAIT_B0`.
- **`WAIT_B1`:** on a clean `byte_valid`, latch byte1 and go to `WAIT_B2`.
- **`WAIT_B2`:** on a clean `byte_valid`, latch byte2 and go to `PUBLISH`.
- **`PUBLISH`:**
  - Lasts one cycle.
  - Loads `x_axis`, `y_axis` and `buttons` and drives `package_done` high.
  - Returns to `WAIT_B0`.
  - A `byte_valid` arriving in this cycle is evaluated as a byte0 candidate, exactly as in `WAIT_B0`.
- **`byte_err` in any state:** discard the partial packet, pulse `pkt_err`, go to `WAIT_B0`.
- **Gap timer:**
  - Runs only in `WAIT_B1` and `WAIT_B2`. It is cleared on every accepted byte and on entry to `WAIT_B0`.
  - When it reaches `TIMEOUT_CYCLES` with no `byte_valid` in that cycle: pulse `pkt_err` and go to `WAIT_B0`.
  - A byte arriving in the same cycle the limit is reached is accepted, and no timeout occurs.
- **Output hold:** outputs hold their last published value between packets. They are never updated by a discarded packet.
- **Overflow bits:** byte0[6] (X overflow) and byte0[7] (Y overflow) are handled according to the Configuration section.

## Timing
- Reset values: `x_axis`=0, `y_axis`=0, `buttons`=0, `package_done`=0, `pkt_err`=0, gap timer=0.
- **Latency:** `package_done` is high exactly 1 cycle after the clock edge that samples the third `byte_valid`. Data outputs change on that same edge.
- **Register sources:** `package_done` and `pkt_err` are direct register outputs, glitch-free. The downstream block uses `package_done` as an edge source.
- **Publish timing:** data outputs are stable at least 1 cycle before `package_done` rises and remain stable while it is high.
- **Reset mid-packet:** the partial packet is discarded silently (no `pkt_err`) and all outputs return to their reset values.
- **Back-to-back packets:** the minimum spacing between `package_done` strobes is 3 cycles.

## Configuration
- Macro `PS2_PKT_SATURATE_EN`.
- **Defined:**
  - If X overflow is set, `x_axis` = 9'h100 (−256) when byte0[4]=1, else 9'h0FF (+255).
  - Y is handled identically using byte0[7] and byte0[5].
- **Undefined:** overflow bits are ignored and the raw 9-bit values are published.

## Structure
- Shared package `ps2_pkg`, containing:
  - the FSM state enum;
  - byte0 bit-position constants (`B0_SYNC`=3, `B0_XSIGN`=4, `B0_YSIGN`=5, `B0_XOVF`=6, `B0_YOVF`=7);
  - the 9-bit axis width constant.
- One sub-module, `ps2_gap_timer`:
  - counter of width $clog2(TIMEOUT_CYCLES+1);
  - inputs: run, clear;
  - output: `expired`.

## Test plan
- **Normal packet:** bytes 0x18, 0x05, 0xFB → `x_axis`=9'h105 (−251), `y_axis`=9'h0FB (+251), `buttons`=0, `package_done` high 1 cycle after the third byte.
- **Resync:** bytes 0x05, 0x08, 0x10, 0x20 → the 0x05 is dropped with `pkt_err`; packet {0x08, 0x10, 0x20} is published: `x_axis`=+16, `y_axis`=+32.
- **Timeout:** byte 0x09, then no byte for `TIMEOUT_CYCLES`+1 cycles → `pkt_err` pulse, no `package_done`; the next packet 0x08, 0x01, 0x01 publishes correctly.
- **Error mid-packet:** byte 0x08, then byte 0x44 with `byte_err`=1 → `pkt_err`, outputs unchanged; the following clean packet is accepted.
- **Overflow:** byte 0x58 (X overflow, X sign=1), 0x00, 0x00 → `x_axis`=9'h100 with `PS2_PKT_SATURATE_EN` defined, 9'h100 raw without it. Byte 0x48, 0x10, 0x00 → 9'h0FF saturated vs 9'h010 raw.
- **Reset mid-packet:** `rst`=0 after byte1 → all outputs 0; after release, a full packet publishes normally.
